sample_streamer: RTL and testbench

SAMPLE_STREAMER -- requirements
Module: sample_streamer

---
 rtl/audio_pkg.sv | 18 +
 rtl/sample_fifo.sv | 57 +++++
 rtl/sample_streamer.sv | 151 +++++++++++++++
 tb/tb_sample_streamer.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared types and default sizing for the sample streamer and its prefetch FIFO.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package audio_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    PLAY = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int DEF_ADDR_W     = 16;
  localparam int DEF_DATA_W     = 32;
  localparam int DEF_SONG_LEN   = 65536;
  localparam int DEF_FIFO_DEPTH = 4;

endpackage

// File: rtl/sample_fifo.sv
// Shift-register FIFO whose head is always entry 0, so o_head comes straight from a flop.
// Latency: a push is visible at o_head on the cycle after the edge that writes it into an empty FIFO.
// Backpressure: push is accepted when not full or when popping in the same cycle; pop on empty is ignored.
module sample_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_flush,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_dat,
  input  logic              i_pop,
  output logic [DATA_W-1:0] o_head,
  output logic              o_full,
  output logic              o_empty,
  output logic [CNT_W-1:0]  o_count
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [CNT_W-1:0]  r_count;
  logic              w_do_pop;
  logic              w_do_push;
  logic [CNT_W-1:0]  w_wr_idx;

  assign w_do_pop  = i_pop && (r_count != '0);
  // A full FIFO may still take a push when the head leaves on the same edge.
  assign w_do_push = i_push && ((r_count != CNT_W'(DEPTH)) || w_do_pop);
  // The write slot sits one lower when the whole array shifts down this cycle.
  assign w_wr_idx  = w_do_pop ? (r_count - CNT_W'(1)) : r_count;

  assign o_head  = r_mem[0];
  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

  // Storage shift on pop, write at the tail slot, occupancy tracking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_count <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_do_push && (w_wr_idx == CNT_W'(i))) begin
          r_mem[i] <= i_dat;
        end else if (w_do_pop) begin
          r_mem[i] <= r_mem[(i + 1) % DEPTH];
        end
      end
      r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
    end
  end

endmodule

// File: rtl/sample_streamer.sv
// Streams song samples from a 1-cycle-latency ROM to an audio controller through a prefetch FIFO.
// Latency: first strobe roughly FIFO_DEPTH+2 cycles after start; then up to one sample per cycle.
// Backpressure: pause / audio_out_allowed hold delivery; fetch stalls once FIFO + in-flight reach FIFO_DEPTH.
// Build option: SONG_LOOP_EN makes the song wrap forever (never reaches DONE).
module sample_streamer
  import audio_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int SONG_LEN   = DEF_SONG_LEN,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              pause,
  input  logic              stop,
  output logic [ADDR_W-1:0] rom_address,
  input  logic [DATA_W-1:0] rom_q,
  input  logic              audio_out_allowed,
  output logic [DATA_W-1:0] left_channel_audio_out,
  output logic [DATA_W-1:0] right_channel_audio_out,
  output logic              write_audio_out,
  output logic              song_done,
  output logic              underrun,
  output logic [ADDR_W-1:0] play_position
);

  localparam int              CNT_W     = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SONG_LEN - 1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_addr;
  logic [ADDR_W-1:0]   r_play_pos;
  logic                r_inflight;
  logic                r_fetch_done;
  logic                r_underrun;

  logic                w_write;
  logic                w_active;
  logic                w_issue;
  logic                w_start_ok;
  logic                w_starve;
  logic [CNT_W-1:0]    w_occ;
  logic [DATA_W-1:0]   w_fifo_head;
  logic                w_fifo_full;
  logic                w_fifo_empty;
  logic [CNT_W-1:0]    w_fifo_count;

  sample_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH),
    .CNT_W  (CNT_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (reset),
    .i_flush (stop),
    .i_push  (r_inflight),
    .i_dat   (rom_q),
    .i_pop   (w_write),
    .o_head  (w_fifo_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );

  assign w_active   = (r_state == FILL) || (r_state == PLAY);
  // Count the read in flight so its returning word always has a slot.
  assign w_occ      = w_fifo_count + CNT_W'(r_inflight);
  assign w_issue    = w_active && !r_fetch_done && (w_occ < CNT_W'(FIFO_DEPTH));
  assign w_start_ok = start && ((r_state == IDLE) || (r_state == DONE));
  assign w_starve   = (r_state == PLAY) && !pause && audio_out_allowed && w_fifo_empty;

  assign rom_address             = r_addr;
  assign play_position           = r_play_pos;
  assign left_channel_audio_out  = w_fifo_empty ? '0 : w_fifo_head;
  assign right_channel_audio_out = w_fifo_empty ? '0 : w_fifo_head;
  assign write_audio_out         = w_write;
  assign song_done               = (r_state == DONE);
  assign underrun                = r_underrun;

  // Playback state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next state and delivery strobe; stop overrides everything.
  always_comb begin
    w_state_nxt = r_state;
    w_write     = (r_state == PLAY) && !pause && audio_out_allowed && !w_fifo_empty;
    if (stop) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE: if (start) w_state_nxt = FILL;
        // Short songs leave FILL once the final word has actually landed.
        FILL: if (w_fifo_full || (r_fetch_done && !r_inflight)) w_state_nxt = PLAY;
        PLAY: begin
`ifndef SONG_LOOP_EN
          if (w_write && (r_play_pos == LAST_ADDR)) w_state_nxt = DONE;
`endif
        end
        DONE: if (start) w_state_nxt = FILL;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // Fetch address, in-flight flag, play position and sticky underrun.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_addr       <= '0;
      r_play_pos   <= '0;
      r_inflight   <= 1'b0;
      r_fetch_done <= 1'b0;
      r_underrun   <= 1'b0;
    end else if (stop) begin
      r_addr       <= '0;
      r_play_pos   <= '0;
      r_inflight   <= 1'b0;
      r_fetch_done <= 1'b0;
    end else if (w_start_ok) begin
      r_addr       <= '0;
      r_play_pos   <= '0;
      r_inflight   <= 1'b0;
      r_fetch_done <= 1'b0;
      r_underrun   <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
`ifdef SONG_LOOP_EN
        r_addr <= (r_addr == LAST_ADDR) ? '0 : r_addr + ADDR_W'(1);
`else
        if (r_addr == LAST_ADDR) r_fetch_done <= 1'b1;
        else                     r_addr       <= r_addr + ADDR_W'(1);
`endif
      end
      if (w_write) begin
`ifdef SONG_LOOP_EN
        r_play_pos <= (r_play_pos == LAST_ADDR) ? '0 : r_play_pos + ADDR_W'(1);
`else
        r_play_pos <= r_play_pos + ADDR_W'(1);
`endif
      end
      if (w_starve) r_underrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sample_streamer.sv
// Scoreboard bench: two streamers (prefetch depth 4 and depth 2) share control inputs and a ROM model.
// Expected strobes are queued when a song is started; a negedge monitor pops and compares.
// Define SONG_LOOP_EN for the looping build.
module tb_sample_streamer;

  localparam int AW = 16;
  localparam int DW = 32;
`ifdef SONG_LOOP_EN
  localparam bit LOOP     = 1'b1;
  localparam int SL       = 4;
  localparam int STOP_POS = 2;
`else
  localparam bit LOOP     = 1'b0;
  localparam int SL       = 8;
  localparam int STOP_POS = 5;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1, start = 1'b0, pause = 1'b0, stop = 1'b0, allowed = 1'b0;

  logic [AW-1:0] a_addr, a_pos, b_addr, b_pos;
  logic [DW-1:0] a_q = '0, b_q = '0, a_left, a_right, b_left, b_right;
  logic          a_wr, a_done, a_urun, b_wr, b_done, b_urun;

  logic [DW-1:0] rom_mem [SL];

  typedef struct {
    logic [DW-1:0] dat;
    logic [AW-1:0] pos;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   na = 0, nb = 0;

  sample_streamer #(.ADDR_W(AW), .DATA_W(DW), .SONG_LEN(SL), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .start(start), .pause(pause), .stop(stop),
    .rom_address(a_addr), .rom_q(a_q), .audio_out_allowed(allowed),
    .left_channel_audio_out(a_left), .right_channel_audio_out(a_right),
    .write_audio_out(a_wr), .song_done(a_done), .underrun(a_urun), .play_position(a_pos)
  );

  sample_streamer #(.ADDR_W(AW), .DATA_W(DW), .SONG_LEN(SL), .FIFO_DEPTH(2)) dut2 (
    .clk(clk), .reset(reset), .start(start), .pause(pause), .stop(stop),
    .rom_address(b_addr), .rom_q(b_q), .audio_out_allowed(allowed),
    .left_channel_audio_out(b_left), .right_channel_audio_out(b_right),
    .write_audio_out(b_wr), .song_done(b_done), .underrun(b_urun), .play_position(b_pos)
  );

  initial forever #5 clk = ~clk;

  // Synchronous ROM: data for an address appears one cycle later.
  always @(posedge clk) begin
    a_q <= rom_mem[int'(a_addr) % SL];
    b_q <= rom_mem[int'(b_addr) % SL];
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // The k-th sample delivered after a start is ROM[k mod SONG_LEN].
  task automatic push_song(input int n);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      e.dat = rom_mem[k % SL];
      e.pos = LOOP ? AW'(k % SL) : AW'(k);
      qa.push_back(e);
      qb.push_back(e);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    qa.delete();
    qb.delete();
    chk("stop_write", a_wr, 0);
    chk("stop_addr", a_addr, 0);
    chk("stop_pos", a_pos, 0);
    chk("stop_left", a_left, 0);
    chk("stop_done", a_done, 0);
  endtask

  task automatic mon_step(input int which, input logic wr, input logic [DW-1:0] l,
                          input logic [DW-1:0] r, input logic [AW-1:0] pos);
    exp_t e;
    if (pause)    chk($sformatf("no_strobe_paused_%0d", which), wr, 0);
    if (!allowed) chk($sformatf("no_strobe_disallowed_%0d", which), wr, 0);
    if (!wr) return;
    if (which == 0) na++; else nb++;
    if ((which == 0 && qa.size() == 0) || (which == 1 && qb.size() == 0)) begin
      n_tests++;
      n_fail++;
      $display("FAIL unexpected_strobe_%0d: got strobe data %0d, expected none", which, l);
      return;
    end
    e = (which == 0) ? qa.pop_front() : qb.pop_front();
    chk($sformatf("left_%0d", which), l, e.dat);
    chk($sformatf("right_%0d", which), r, e.dat);
    chk($sformatf("pos_%0d", which), pos, e.pos);
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      mon_step(0, a_wr, a_left, a_right, a_pos);
      mon_step(1, b_wr, b_left, b_right, b_pos);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    for (int i = 0; i < SL; i++) rom_mem[i] = DW'(i + 1);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_addr", a_addr, 0);
    chk("rst_pos", a_pos, 0);
    chk("rst_write", a_wr, 0);
    chk("rst_done", a_done, 0);
    chk("rst_urun", a_urun, 0);
    chk("rst_left", a_left, 0);
    chk("rst_right", a_right, 0);
    chk("rst_done_b", b_done, 0);
    reset = 1'b0;
    tick();

    // Basic play with the controller always ready.
    na = 0; nb = 0; allowed = 1'b1;
    push_song(LOOP ? 1000 : SL);
    pulse_start();
    g = 0;
    if (LOOP) begin
      while (na < 10 && g < 300) begin tick(); g++; end
      chk("loop_ten_strobes", na >= 10, 1);
      chk("loop_done_a", a_done, 0);
      chk("loop_done_b", b_done, 0);
      chk("urun_a_basic", a_urun, 0);
      while (nb < 3 && g < 300) begin tick(); g++; end
      chk("urun_b_basic", b_urun, 1);
      do_stop();
    end else begin
      while (!(a_done && b_done) && g < 300) begin tick(); g++; end
      chk("basic_done_a", a_done, 1);
      chk("basic_done_b", b_done, 1);
      chk("basic_pos_a", a_pos, SL);
      chk("basic_pos_b", b_pos, SL);
      chk("basic_count_a", na, SL);
      chk("basic_queue_b", qb.size(), 0);
      chk("urun_a_basic", a_urun, 0);
      chk("urun_b_basic", b_urun, 1);
    end

    // Pause after the third strobe, with an ignored start, then stop mid-song.
    na = 0; nb = 0; allowed = 1'b1;
    push_song(LOOP ? 1000 : SL);
    pulse_start();
    g = 0;
    while (na < 3 && g < 300) begin tick(); g++; end
    chk("pause_reached_three", na, 3);
    pause = 1'b1;
    repeat (10) tick();
    pulse_start();
    repeat (9) tick();
    pause = 1'b0;
    @(negedge clk);
    chk("resume_strobe_full", a_wr, 1);
    chk("resume_left", a_left, rom_mem[3 % SL]);
    tick();
    g = 0;
    while (a_pos != AW'(STOP_POS) && g < 300) begin
      allowed = ($urandom_range(0, 3) != 0);
      tick();
      g++;
    end
    chk("stop_at_pos", a_pos, STOP_POS);
    allowed = 1'b1;
    do_stop();
    chk("urun_held_by_stop", b_urun, 1);

    // Random ROM contents, random backpressure and pauses; replay starts at sample 0.
    for (int i = 0; i < SL; i++) rom_mem[i] = $urandom;
    na = 0; nb = 0;
    push_song(LOOP ? 1000 : SL);
    pulse_start();
    chk("start_clears_urun", b_urun, 0);
    g = 0;
    while ((LOOP ? (na < 30) : !(a_done && b_done)) && g < 3000) begin
      allowed = ($urandom_range(0, 3) != 0);
      pause   = ($urandom_range(0, 7) == 0);
      tick();
      g++;
    end
    allowed = 1'b1;
    pause   = 1'b0;
    chk("rand_urun_a", a_urun, 0);
    if (LOOP) begin
      chk("rand_loop_count", na >= 30, 1);
      chk("rand_loop_done", a_done, 0);
      do_stop();
    end else begin
      chk("rand_done_a", a_done, 1);
      chk("rand_done_b", b_done, 1);
      chk("rand_pos_a", a_pos, SL);
      chk("rand_queue_a", qa.size(), 0);
      chk("rand_queue_b", qb.size(), 0);
    end

    // Async reset while a ROM read is outstanding.
    for (int i = 0; i < SL; i++) rom_mem[i] = DW'(i + 1);
    pulse_start();
    tick();
    chk("first_read_addr", a_addr, 1);
    reset = 1'b1;
    #1;
    chk("arst_addr", a_addr, 0);
    chk("arst_pos", a_pos, 0);
    chk("arst_write", a_wr, 0);
    chk("arst_done", a_done, 0);
    chk("arst_urun", a_urun, 0);
    chk("arst_left", a_left, 0);
    chk("arst_right", a_right, 0);
    chk("arst_addr_b", b_addr, 0);
    #1;
    reset = 1'b0;
    qa.delete();
    qb.delete();
    tick();
    chk("no_push_after_rst_a", a_left, 0);
    chk("no_push_after_rst_b", b_left, 0);
    tick();
    chk("still_empty_a", a_left, 0);
    chk("still_idle_addr", a_addr, 0);

    // Clean replay after the reset.
    na = 0; nb = 0; allowed = 1'b1;
    push_song(LOOP ? 1000 : SL);
    pulse_start();
    g = 0;
    while ((LOOP ? (na < SL + 2) : !(a_done && b_done)) && g < 300) begin tick(); g++; end
    if (LOOP) begin
      chk("replay_loop_count", na >= SL + 2, 1);
      chk("replay_loop_done", a_done, 0);
      do_stop();
    end else begin
      chk("replay_done_a", a_done, 1);
      chk("replay_pos_a", a_pos, SL);
      chk("replay_count_a", na, SL);
      chk("replay_count_b", nb, SL);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
